// File: rtl/morty_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : morty_wb_pkg
//  Brief    : Shared constants for the two-master Wishbone arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package morty_wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_GNT_M0 = 2'd1;
    localparam state_t ST_GNT_M1 = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : wb_watchdog
//  Brief    : Counts stalled cycles of a granted transfer; flags expiry.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_enabled
            localparam logic [TO_W-1:0] c_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

            logic [TO_W-1:0] r_cnt;

            always_ff @(posedge clk_i) begin
                if (rst_i || clr_i) begin
                    r_cnt <= '0;
                end else if (run_i) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // Fires in the last allowed stalled cycle, so the error is seen while still granted
            assign expire_o = run_i && (r_cnt == c_LIMIT);
        end else begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk_i, rst_i, clr_i, run_i};
            assign expire_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_master_arbiter
//  Brief    : Round-robin arbiter sharing one Wishbone slave between two masters.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_master_arbiter
    import morty_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // M0: instruction fetch
    input  logic [WB_AW-1:0] wbm0_addr_i,
    input  logic [WB_DW-1:0] wbm0_dat_i,
    input  logic [WB_SW-1:0] wbm0_sel_i,
    input  logic             wbm0_cyc_i,
    input  logic             wbm0_stb_i,
    input  logic             wbm0_we_i,
    output logic [WB_DW-1:0] wbm0_dat_o,
    output logic             wbm0_ack_o,
    output logic             wbm0_err_o,
    // M1: data / memory stage
    input  logic [WB_AW-1:0] wbm1_addr_i,
    input  logic [WB_DW-1:0] wbm1_dat_i,
    input  logic [WB_SW-1:0] wbm1_sel_i,
    input  logic             wbm1_cyc_i,
    input  logic             wbm1_stb_i,
    input  logic             wbm1_we_i,
    output logic [WB_DW-1:0] wbm1_dat_o,
    output logic             wbm1_ack_o,
    output logic             wbm1_err_o,
    // Shared slave
    output logic [WB_AW-1:0] wbs_addr_o,
    output logic [WB_DW-1:0] wbs_dat_o,
    output logic [WB_SW-1:0] wbs_sel_o,
    output logic             wbs_cyc_o,
    output logic             wbs_stb_o,
    output logic             wbs_we_o,
    input  logic [WB_DW-1:0] wbs_dat_i,
    input  logic             wbs_ack_i,
    input  logic             wbs_err_i,
    // Status
    output logic [1:0]       grant_o,
    output logic             timeout_o
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_last_gnt;

    logic w_req0;
    logic w_req1;
    logic w_granted;
    logic w_expire;
    logic w_term;

    assign w_req0    = wbm0_cyc_i & wbm0_stb_i;
    assign w_req1    = wbm1_cyc_i & wbm1_stb_i;
    assign w_granted = (r_state == ST_GNT_M0) || (r_state == ST_GNT_M1);
    assign w_term    = wbs_ack_i | wbs_err_i | w_expire;

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (!w_granted),
        .run_i    (w_granted && !wbs_ack_i && !wbs_err_i),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= GNT_M0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_GNT_M0 && r_state == ST_IDLE) begin
                r_last_gnt <= GNT_M0;
            end else if (w_state_nxt == ST_GNT_M1 && r_state == ST_IDLE) begin
                r_last_gnt <= GNT_M1;
            end
        end
    end

    // Every grant ends in IDLE, which gives the mandatory one-cycle turnaround
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 && w_req1) begin
                    w_state_nxt = (r_last_gnt == GNT_M0) ? ST_GNT_M1 : ST_GNT_M0;
                end else if (w_req1) begin
                    w_state_nxt = ST_GNT_M1;
                end else if (w_req0) begin
                    w_state_nxt = ST_GNT_M0;
                end
            end
            ST_GNT_M0: if (w_term || !wbm0_cyc_i) w_state_nxt = ST_IDLE;
            ST_GNT_M1: if (w_term || !wbm1_cyc_i) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wbs_addr_o = '0;
        wbs_dat_o  = '0;
        wbs_sel_o  = '0;
        wbs_cyc_o  = 1'b0;
        wbs_stb_o  = 1'b0;
        wbs_we_o   = 1'b0;
        wbm0_dat_o = '0;
        wbm0_ack_o = 1'b0;
        wbm0_err_o = 1'b0;
        wbm1_dat_o = '0;
        wbm1_ack_o = 1'b0;
        wbm1_err_o = 1'b0;
        grant_o    = GNT_NONE;
        case (r_state)
            ST_GNT_M0: begin
                wbs_addr_o = wbm0_addr_i;
                wbs_dat_o  = wbm0_dat_i;
                wbs_sel_o  = wbm0_sel_i;
                wbs_cyc_o  = wbm0_cyc_i;
                wbs_stb_o  = wbm0_stb_i;
                wbs_we_o   = wbm0_we_i;
                wbm0_dat_o = wbs_dat_i;
                wbm0_ack_o = wbs_ack_i;
                wbm0_err_o = wbs_err_i | w_expire;
                grant_o    = GNT_M0;
            end
            ST_GNT_M1: begin
                wbs_addr_o = wbm1_addr_i;
                wbs_dat_o  = wbm1_dat_i;
                wbs_sel_o  = wbm1_sel_i;
                wbs_cyc_o  = wbm1_cyc_i;
                wbs_stb_o  = wbm1_stb_i;
                wbs_we_o   = wbm1_we_i;
                wbm1_dat_o = wbs_dat_i;
                wbm1_ack_o = wbs_ack_i;
                wbm1_err_o = wbs_err_i | w_expire;
                grant_o    = GNT_M1;
            end
            default: ;
        endcase
    end

    assign timeout_o = w_expire;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_master_arbiter
//  Brief    : Self-checking bench for wb_master_arbiter (watchdog set to 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_master_arbiter;

    localparam int TIMEOUT_CYCLES = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] wbm0_addr_i, wbm0_dat_i, wbm0_dat_o;
    logic [3:0]  wbm0_sel_i;
    logic        wbm0_cyc_i, wbm0_stb_i, wbm0_we_i, wbm0_ack_o, wbm0_err_o;
    logic [31:0] wbm1_addr_i, wbm1_dat_i, wbm1_dat_o;
    logic [3:0]  wbm1_sel_i;
    logic        wbm1_cyc_i, wbm1_stb_i, wbm1_we_i, wbm1_ack_o, wbm1_err_o;
    logic [31:0] wbs_addr_o, wbs_dat_o, wbs_dat_i;
    logic [3:0]  wbs_sel_o;
    logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i, wbs_err_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    wb_master_arbiter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wbm0_addr_i (wbm0_addr_i),
        .wbm0_dat_i  (wbm0_dat_i),
        .wbm0_sel_i  (wbm0_sel_i),
        .wbm0_cyc_i  (wbm0_cyc_i),
        .wbm0_stb_i  (wbm0_stb_i),
        .wbm0_we_i   (wbm0_we_i),
        .wbm0_dat_o  (wbm0_dat_o),
        .wbm0_ack_o  (wbm0_ack_o),
        .wbm0_err_o  (wbm0_err_o),
        .wbm1_addr_i (wbm1_addr_i),
        .wbm1_dat_i  (wbm1_dat_i),
        .wbm1_sel_i  (wbm1_sel_i),
        .wbm1_cyc_i  (wbm1_cyc_i),
        .wbm1_stb_i  (wbm1_stb_i),
        .wbm1_we_i   (wbm1_we_i),
        .wbm1_dat_o  (wbm1_dat_o),
        .wbm1_ack_o  (wbm1_ack_o),
        .wbm1_err_o  (wbm1_err_o),
        .wbs_addr_o  (wbs_addr_o),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_sel_o   (wbs_sel_o),
        .wbs_cyc_o   (wbs_cyc_o),
        .wbs_stb_o   (wbs_stb_o),
        .wbs_we_o    (wbs_we_o),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_i   (wbs_ack_i),
        .wbs_err_i   (wbs_err_i),
        .grant_o     (grant_o),
        .timeout_o   (timeout_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        wbm0_addr_i = '0; wbm0_dat_i = '0; wbm0_sel_i = '0;
        wbm0_cyc_i = 0; wbm0_stb_i = 0; wbm0_we_i = 0;
        wbm1_addr_i = '0; wbm1_dat_i = '0; wbm1_sel_i = '0;
        wbm1_cyc_i = 0; wbm1_stb_i = 0; wbm1_we_i = 0;
        wbs_dat_i = '0; wbs_ack_i = 0; wbs_err_i = 0;
    endtask

    task automatic m0_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic we);
        wbm0_addr_i = a; wbm0_dat_i = d; wbm0_sel_i = s; wbm0_we_i = we;
        wbm0_cyc_i = 1; wbm0_stb_i = 1;
    endtask

    task automatic m1_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic we);
        wbm1_addr_i = a; wbm1_dat_i = d; wbm1_sel_i = s; wbm1_we_i = we;
        wbm1_cyc_i = 1; wbm1_stb_i = 1;
    endtask

    task automatic do_reset();
        rst_i = 1;
        tick();
        rst_i = 0;
        idle_all();
    endtask

    task automatic test_reset();
        idle_all();
        rst_i = 1;
        m0_req(32'h10, 32'h0, 4'hF, 0);
        m1_req(32'h20, 32'h0, 4'hF, 0);
        wbs_ack_i = 1;
        tick(); tick();
        #1;
        n_chk++; if (grant_o !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant_o); else n_pass++;
        n_chk++; if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o} !== 7'b0) $display("FAIL reset_bus_ctrl: got %b want 0", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o}); else n_pass++;
        n_chk++; if ({wbs_addr_o, wbs_dat_o} !== 64'h0) $display("FAIL reset_bus_data: got %h want 0", {wbs_addr_o, wbs_dat_o}); else n_pass++;
        n_chk++; if ({wbm0_ack_o, wbm0_err_o, wbm1_ack_o, wbm1_err_o, timeout_o} !== 5'b0) $display("FAIL reset_term: got %b want 00000", {wbm0_ack_o, wbm0_err_o, wbm1_ack_o, wbm1_err_o, timeout_o}); else n_pass++;
        rst_i = 0;
        idle_all();
        tick();
    endtask

    task automatic test_m0_read();
        idle_all();
        m0_req(32'h0000_0100, 32'h0, 4'hF, 0);
        #1;
        n_chk++; if ({grant_o, wbs_cyc_o} !== 3'b000) $display("FAIL m0rd_latency: got %b want 000", {grant_o, wbs_cyc_o}); else n_pass++;
        tick(); #1;
        n_chk++; if ({grant_o, wbs_cyc_o, wbs_stb_o, wbs_we_o} !== 5'b01110) $display("FAIL m0rd_grant: got %b want 01110", {grant_o, wbs_cyc_o, wbs_stb_o, wbs_we_o}); else n_pass++;
        n_chk++; if (wbs_addr_o !== 32'h0000_0100) $display("FAIL m0rd_addr: got %h want 00000100", wbs_addr_o); else n_pass++;
        tick();
        tick();
        wbs_ack_i = 1; wbs_dat_i = 32'hCAFE_0100;
        #1;
        n_chk++; if ({wbm0_ack_o, wbm0_err_o, wbm1_ack_o} !== 3'b100) $display("FAIL m0rd_ack: got %b want 100", {wbm0_ack_o, wbm0_err_o, wbm1_ack_o}); else n_pass++;
        n_chk++; if (wbm0_dat_o !== 32'hCAFE_0100) $display("FAIL m0rd_dat: got %h want cafe0100", wbm0_dat_o); else n_pass++;
        n_chk++; if (wbm1_dat_o !== 32'h0) $display("FAIL m0rd_m1dat: got %h want 0", wbm1_dat_o); else n_pass++;
        tick();
        idle_all();
        #1;
        n_chk++; if ({grant_o, wbs_cyc_o, wbm0_ack_o} !== 4'b0000) $display("FAIL m0rd_idle: got %b want 0000", {grant_o, wbs_cyc_o, wbm0_ack_o}); else n_pass++;
    endtask

    task automatic test_tie_alternation();
        do_reset();
        m0_req(32'hA000_0000, 32'h0, 4'hF, 0);
        m1_req(32'hB000_0000, 32'h0, 4'hF, 0);
        #1;
        n_chk++; if (grant_o !== 2'b00) $display("FAIL tie_wait: got %b want 00", grant_o); else n_pass++;
        tick(); #1;
        n_chk++; if (grant_o !== 2'b10) $display("FAIL tie_first_m1: got %b want 10", grant_o); else n_pass++;
        n_chk++; if (wbs_addr_o !== 32'hB000_0000) $display("FAIL tie_m1_addr: got %h want b0000000", wbs_addr_o); else n_pass++;
        wbs_ack_i = 1;
        #1;
        n_chk++; if ({wbm0_ack_o, wbm1_ack_o} !== 2'b01) $display("FAIL tie_m1_ack: got %b want 01", {wbm0_ack_o, wbm1_ack_o}); else n_pass++;
        tick();
        wbs_ack_i = 0; wbm1_cyc_i = 0; wbm1_stb_i = 0;
        #1;
        n_chk++; if ({grant_o, wbs_cyc_o} !== 3'b000) $display("FAIL tie_turnaround: got %b want 000", {grant_o, wbs_cyc_o}); else n_pass++;
        tick(); #1;
        n_chk++; if (grant_o !== 2'b01) $display("FAIL tie_then_m0: got %b want 01", grant_o); else n_pass++;
        wbs_ack_i = 1;
        tick();
        // M0 keeps cyc up after its ack and M1 requests again: a fresh tie
        wbs_ack_i = 0;
        m1_req(32'hB000_0004, 32'h0, 4'hF, 0);
        #1;
        n_chk++; if (grant_o !== 2'b00) $display("FAIL tie2_idle: got %b want 00", grant_o); else n_pass++;
        tick(); #1;
        n_chk++; if (grant_o !== 2'b10) $display("FAIL tie2_m1: got %b want 10", grant_o); else n_pass++;
        wbs_ack_i = 1;
        tick();
        wbs_ack_i = 0; wbm1_cyc_i = 0; wbm1_stb_i = 0;
        tick(); #1;
        n_chk++; if (grant_o !== 2'b01) $display("FAIL tie2_m0: got %b want 01", grant_o); else n_pass++;
        wbs_ack_i = 1;
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_m1_write();
        idle_all();
        m1_req(32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 1);
        tick();
        m0_req(32'h0000_0300, 32'h0, 4'hF, 0);
        #1;
        n_chk++; if ({grant_o, wbs_we_o, wbs_cyc_o} !== 4'b1011) $display("FAIL m1wr_ctrl: got %b want 1011", {grant_o, wbs_we_o, wbs_cyc_o}); else n_pass++;
        n_chk++; if ({wbs_addr_o, wbs_dat_o, wbs_sel_o} !== {32'h0000_2000, 32'hDEAD_BEEF, 4'b0011}) $display("FAIL m1wr_data: got %h/%h/%b want 00002000/deadbeef/0011", wbs_addr_o, wbs_dat_o, wbs_sel_o); else n_pass++;
        tick(); #1;
        n_chk++; if (grant_o !== 2'b10) $display("FAIL m1wr_m0_waits: got %b want 10", grant_o); else n_pass++;
        wbs_ack_i = 1;
        #1;
        n_chk++; if ({wbm1_ack_o, wbm0_ack_o} !== 2'b10) $display("FAIL m1wr_ack: got %b want 10", {wbm1_ack_o, wbm0_ack_o}); else n_pass++;
        tick();
        wbs_ack_i = 0; wbm1_cyc_i = 0; wbm1_stb_i = 0;
        tick(); #1;
        n_chk++; if ({grant_o, wbs_addr_o} !== {2'b01, 32'h0000_0300}) $display("FAIL m1wr_then_m0: got %b/%h want 01/00000300", grant_o, wbs_addr_o); else n_pass++;
        wbs_ack_i = 1;
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_timeout();
        idle_all();
        m0_req(32'h0000_0400, 32'h0, 4'hF, 0);
        tick();
        for (int k = 0; k < TIMEOUT_CYCLES - 1; k++) begin
            #1;
            n_chk++; if ({wbm0_err_o, timeout_o} !== 2'b00) $display("FAIL to_early_%0d: got %b want 00", k, {wbm0_err_o, timeout_o}); else n_pass++;
            tick();
        end
        #1;
        n_chk++; if ({wbm0_err_o, timeout_o, wbm0_ack_o, wbs_cyc_o} !== 4'b1101) $display("FAIL to_fire: got %b want 1101", {wbm0_err_o, timeout_o, wbm0_ack_o, wbs_cyc_o}); else n_pass++;
        tick();
        idle_all();
        #1;
        n_chk++; if ({wbs_cyc_o, wbs_stb_o, grant_o, timeout_o, wbm0_err_o} !== 6'b0) $display("FAIL to_release: got %b want 000000", {wbs_cyc_o, wbs_stb_o, grant_o, timeout_o, wbm0_err_o}); else n_pass++;
        tick();
        wbs_ack_i = 1; wbs_dat_i = 32'h1234_5678;
        #1;
        n_chk++; if ({wbm0_ack_o, wbm1_ack_o, wbm0_dat_o} !== 34'h0) $display("FAIL to_late_ack: got %b/%h want 00/0", {wbm0_ack_o, wbm1_ack_o}, wbm0_dat_o); else n_pass++;
        tick();
        idle_all();
    endtask

    task automatic test_reset_mid();
        idle_all();
        m1_req(32'h0000_5000, 32'h5555_AAAA, 4'hF, 1);
        tick(); #1;
        n_chk++; if (grant_o !== 2'b10) $display("FAIL rstmid_pre: got %b want 10", grant_o); else n_pass++;
        rst_i = 1;
        tick();
        rst_i = 0;
        m0_req(32'h0000_6000, 32'h0, 4'hF, 0);
        #1;
        n_chk++; if ({grant_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o} !== 9'b0) $display("FAIL rstmid_ctrl: got %b want 0", {grant_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o}); else n_pass++;
        n_chk++; if ({wbs_addr_o, wbs_dat_o} !== 64'h0) $display("FAIL rstmid_bus: got %h want 0", {wbs_addr_o, wbs_dat_o}); else n_pass++;
        tick(); #1;
        n_chk++; if (grant_o !== 2'b10) $display("FAIL rstmid_tie: got %b want 10", grant_o); else n_pass++;
        wbs_ack_i = 1;
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_err();
        idle_all();
        m0_req(32'h0000_0700, 32'h0, 4'hF, 0);
        tick();
        wbs_err_i = 1;
        #1;
        n_chk++; if ({wbm0_err_o, wbm0_ack_o, wbm1_err_o} !== 3'b100) $display("FAIL err_fwd: got %b want 100", {wbm0_err_o, wbm0_ack_o, wbm1_err_o}); else n_pass++;
        tick();
        wbs_err_i = 0;
        #1;
        n_chk++; if ({wbm0_err_o, grant_o} !== 3'b000) $display("FAIL err_one_cycle: got %b want 000", {wbm0_err_o, grant_o}); else n_pass++;
        tick();
        idle_all();
        tick();
    endtask

    // Random traffic against a transaction-level model: owner, last winner, stalled cycles
    task automatic test_random();
        logic        act  [2];
        logic [31:0] maddr[2];
        logic [31:0] mdat [2];
        logic [3:0]  msel [2];
        logic        mwe  [2];
        int          own, last, wt, o, r;
        logic        ack, err, exp_to, term;
        logic [1:0]  exp_grant;
        logic [5:0]  exp_ctrl;
        logic [31:0] exp_addr, exp_wdat, sdat;
        logic [3:0]  exp_term;

        do_reset();
        own = 0; last = 1; wt = 0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; maddr[i] = '0; mdat[i] = '0; msel[i] = '0; mwe[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!act[i]) begin
                    if ($urandom % 2 == 0) begin
                        act[i] = 1; maddr[i] = $urandom; mdat[i] = $urandom;
                        msel[i] = 4'($urandom); mwe[i] = 1'($urandom);
                    end
                end else if ($urandom % 20 == 0) begin
                    act[i] = 0;
                end
            end
            wbm0_addr_i = maddr[0]; wbm0_dat_i = mdat[0]; wbm0_sel_i = msel[0];
            wbm0_we_i = mwe[0]; wbm0_cyc_i = act[0]; wbm0_stb_i = act[0];
            wbm1_addr_i = maddr[1]; wbm1_dat_i = mdat[1]; wbm1_sel_i = msel[1];
            wbm1_we_i = mwe[1]; wbm1_cyc_i = act[1]; wbm1_stb_i = act[1];
            r = $urandom % 7;
            ack = (own != 0) ? (r < 2 || r == 3) : (r == 0);
            err = (own != 0) && (r == 2 || r == 3);
            sdat = $urandom;
            wbs_ack_i = ack; wbs_err_i = err; wbs_dat_i = sdat;
            #1;
            o = (own == 0) ? 0 : own - 1;
            exp_to    = (own != 0) && !ack && !err && (wt == TIMEOUT_CYCLES - 1);
            exp_grant = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
            exp_ctrl  = (own != 0) ? {act[o], act[o], mwe[o], msel[o][2:0]} : 6'b0;
            exp_addr  = (own != 0) ? maddr[o] : 32'h0;
            exp_wdat  = (own != 0) ? mdat[o] : 32'h0;
            exp_term  = {own == 1 && ack, own == 1 && (err || exp_to), own == 2 && ack, own == 2 && (err || exp_to)};
            n_chk++; if ({grant_o, timeout_o} !== {exp_grant, exp_to}) $display("FAIL rnd_grant c%0d: got %b want %b", cyc, {grant_o, timeout_o}, {exp_grant, exp_to}); else n_pass++;
            n_chk++; if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o[2:0]} !== exp_ctrl || wbs_sel_o[3] !== ((own != 0) ? msel[o][3] : 1'b0)) $display("FAIL rnd_ctrl c%0d: got %b%b want %b", cyc, wbs_sel_o[3], {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o[2:0]}, exp_ctrl); else n_pass++;
            n_chk++; if ({wbs_addr_o, wbs_dat_o} !== {exp_addr, exp_wdat}) $display("FAIL rnd_bus c%0d: got %h want %h", cyc, {wbs_addr_o, wbs_dat_o}, {exp_addr, exp_wdat}); else n_pass++;
            n_chk++; if ({wbm0_ack_o, wbm0_err_o, wbm1_ack_o, wbm1_err_o} !== exp_term) $display("FAIL rnd_term c%0d: got %b want %b", cyc, {wbm0_ack_o, wbm0_err_o, wbm1_ack_o, wbm1_err_o}, exp_term); else n_pass++;
            n_chk++; if ({wbm0_dat_o, wbm1_dat_o} !== {(own == 1) ? sdat : 32'h0, (own == 2) ? sdat : 32'h0}) $display("FAIL rnd_rdat c%0d: got %h/%h", cyc, wbm0_dat_o, wbm1_dat_o); else n_pass++;
            if (own != 0) begin
                term = ack || err || exp_to || !act[o];
                if (ack || err || exp_to) act[o] = 0;
                if (term) own = 0;
                else wt++;
            end else begin
                if (act[0] && act[1]) own = (last == 1) ? 2 : 1;
                else if (act[1]) own = 2;
                else if (act[0]) own = 1;
                if (own != 0) begin
                    last = own;
                    wt = 0;
                end
            end
            tick();
        end
        idle_all();
        tick();
    endtask

    initial begin
        idle_all();
        rst_i = 1;
        #2;
        test_reset();
        test_m0_read();
        test_tie_alternation();
        test_m1_write();
        test_timeout();
        test_reset_mid();
        test_err();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got no completion want completion");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
